// File: rtl/cpu_pkg.sv
// Shared types and helpers for the CPU datapath blocks around the memory data register.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mdr_state_t;

  localparam int BYTE_W = 8;

  function automatic int lane_count(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/mdr_watchdog.sv
// Wait-cycle counter for the MDR handshake; flags expiry on the TIMEOUT-th cycle spent waiting.
module mdr_watchdog #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Terminal value is TIMEOUT-1 so expiry lands at the end of the TIMEOUT-th wait cycle.
  localparam logic [CNT_W-1:0] TERM = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r;

  // Wait-cycle counter: cleared on transaction entry, advancing while a transaction is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (TIMEOUT > 0) && en && (cnt_r == TERM);

endmodule

// File: rtl/mdr_hs.sv
// Memory data register with a req/ack main-memory handshake, byte-lane loads/stores and a bus watchdog.
module mdr_hs
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     bus_in,
  output logic [DATA_W-1:0]     bus_out,
  output logic                  bus_oe,
  input  logic                  mdr_in,
  input  logic                  mdr_out,
  input  logic                  read_from_mm,
  input  logic                  write_to_mm,
  input  logic                  byte_mode,
  input  logic                  sign_ext,
  output logic [DATA_W-1:0]     reg_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  bus_err,
  input  logic                  err_clr
);

  localparam int LANES = lane_count(DATA_W);

  mdr_state_t        state_r, state_nxt_s;
  logic [DATA_W-1:0] r_r;
  logic              byte_r, sext_r;
  logic              start_wr_s, start_rd_s, done_s, timeout_s, wd_expired_s;
  logic [LANES-1:0]  be_s;

  function automatic logic [DATA_W-1:0] rd_capture(input logic [DATA_W-1:0] d,
                                                   input logic is_byte, input logic sx);
    if (is_byte) begin
      return {{(DATA_W-BYTE_W){sx & d[BYTE_W-1]}}, d[BYTE_W-1:0]};
    end else begin
      return d;
    end
  endfunction

  mdr_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_wr_s | start_rd_s),
    .en      (state_r != IDLE),
    .expired (wd_expired_s)
  );

  // Next-state decode; a write request beats a simultaneous read, an ack beats a timeout.
  always_comb begin
    state_nxt_s = state_r;
    start_wr_s  = 1'b0;
    start_rd_s  = 1'b0;
    done_s      = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (write_to_mm) begin
          start_wr_s  = 1'b1;
          state_nxt_s = WR_WAIT;
        end else if (read_from_mm) begin
          start_rd_s  = 1'b1;
          state_nxt_s = RD_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ack) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else if (wd_expired_s) begin
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  assign be_s = byte_mode ? {{(LANES-1){1'b0}}, 1'b1} : {LANES{1'b1}};

  // State, handshake outputs and transaction attributes, all held stable while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= {LANES{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      byte_r    <= 1'b0;
      sext_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s != IDLE);
      if (start_wr_s) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_be    <= be_s;
        mem_wdata <= mdr_in ? bus_in : r_r;
      end else if (start_rd_s) begin
        mem_req <= 1'b1;
        mem_we  <= 1'b0;
        mem_be  <= be_s;
        byte_r  <= byte_mode;
        sext_r  <= sign_ext;
      end else if (done_s | timeout_s) begin
        mem_req <= 1'b0;
      end else begin
        mem_req <= mem_req;
      end
    end
  end

  // Data register: bus loads only in IDLE, read capture only on an acknowledged read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_r <= {DATA_W{1'b0}};
    end else if ((state_r == IDLE) && mdr_in) begin
      r_r <= bus_in;
    end else if (done_s && (state_r == RD_WAIT)) begin
      r_r <= rd_capture(mem_rdata, byte_r, sext_r);
    end else begin
      r_r <= r_r;
    end
  end

  // Sticky bus error; a timeout in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else if (timeout_s) begin
      bus_err <= 1'b1;
    end else if (err_clr) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= bus_err;
    end
  end

  assign bus_out = r_r;
  assign bus_oe  = mdr_out;
  assign reg_out = (mdr_in && write_to_mm && (state_r == IDLE)) ? bus_in : r_r;

endmodule

// File: doc/mdr_hs.md
Name: mdr_hs

Overview:
- Parametrised memory data register with a request/acknowledge main-memory handshake, replacing the fixed-latency, single-cycle MDR model.
- Sits between the internal CPU bus and the RAM controller. Holds one data word.
- Runs variable-latency reads and writes, and reports `busy` so the control unit can stall.
- Adds an optional byte-lane mode (zero- or sign-extended byte loads, byte stores) and a watchdog timeout that flags a bus error.

Parameters:
- DATA_W, 16, data word width in bits; must be a multiple of 8 and at least 16.
- TIMEOUT, 15, maximum cycles to wait for `mem_ack` before aborting; 0 disables the watchdog.
- CNT_W, 4, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- bus_in  input  DATA_W  data from the internal bus.
- bus_out  output  DATA_W  register value presented to the bus driver.
- bus_oe  output  1  equals `mdr_out`; the top-level tri-state driver uses it.
- mdr_in  input  1  load the register from `bus_in`.
- mdr_out  input  1  drive the register onto the bus.
- read_from_mm  input  1  start a memory read (single-cycle pulse).
- write_to_mm  input  1  start a memory write (single-cycle pulse).
- byte_mode  input  1  byte access, sampled at the start of a transaction.
- sign_ext  input  1  sign-extend byte reads, sampled at the start of a transaction.
- reg_out  output  DATA_W  current register value, or the bypass value (see Behaviour).
- mem_req  output  1  memory request, held until acknowledged.
- mem_we  output  1  1 = write, 0 = read; valid while `mem_req` is high.
- mem_be  output  DATA_W/8  byte enables; all ones for word access, bit 0 only for byte access.
- mem_wdata  output  DATA_W  write data, stable while `mem_req` is high.
- mem_rdata  input  DATA_W  read data, valid in the cycle `mem_ack` is high.
- mem_ack  input  1  memory acknowledge, one cycle.
- busy  output  1  a transaction is in flight.
- bus_err  output  1  sticky timeout flag.
- err_clr  input  1  clears `bus_err`.

Behaviour:
- Reset (asynchronous): register r=0, state=IDLE, watchdog=0, mem_req=0, mem_we=0, mem_wdata=0, mem_be=0, bus_err=0, busy=0.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE, read_from_mm=1:
  - Go to RD_WAIT next cycle.
  - mem_req=1, mem_we=0 are registered, so they assert the cycle after the pulse.
  - Latch mem_be and the sign_ext mode.
- IDLE, write_to_mm=1:
  - Go to WR_WAIT.
  - Latch mem_wdata = bus_in if mdr_in=1 in the same cycle; otherwise mem_wdata = r.
  - If mdr_in=1 in that cycle, r also loads bus_in.
  - mem_req=1, mem_we=1.
- read_from_mm and write_to_mm both high in IDLE: write wins, the read is dropped.
- IDLE, mdr_in alone: r <= bus_in at the next clock edge.
- RD_WAIT or WR_WAIT:
  - busy=1; mem_req, mem_we, mem_be, mem_wdata are held stable.
  - read_from_mm, write_to_mm and mdr_in are ignored, and r is frozen except for the read capture.
- On mem_ack in RD_WAIT:
  - Word access: r <= mem_rdata.
  - Byte access: r <= {ext, mem_rdata[7:0]}, where ext is the replicated mem_rdata[7] if sign_ext else zeros.
  - Return to IDLE with mem_req=0 in the next cycle.
  - Read latency = 1 (request) + memory wait + 1 (capture), so a zero-wait memory completes in 2 cycles.
- On mem_ack in WR_WAIT: return to IDLE; r is unchanged.
- mem_ack while in IDLE: ignored.
- Watchdog:
  - Counts cycles in RD_WAIT/WR_WAIT and clears on entry.
  - If TIMEOUT>0 and the count reaches TIMEOUT without mem_ack: drop mem_req, set bus_err=1, return to IDLE. r is unchanged.
  - mem_ack in the same cycle as the timeout: the ack wins, no error.
- bus_err is sticky. err_clr clears it; if a timeout coincides with err_clr, set wins.
- bus_out = r at all times; bus_oe = mdr_out (combinational).
- reg_out = bus_in when (mdr_in & write_to_mm & state==IDLE); otherwise reg_out = r.
- busy = (state != IDLE); registered.
- Reset asserted mid-transaction: immediately returns to IDLE, mem_req=0, no capture.

Decomposition:
- Shared package cpu_pkg:
  - `mdr_state_t` enum {IDLE, RD_WAIT, WR_WAIT}
  - BYTE_W=8
  - `lane_count` function: DATA_W/8
- Sub-module `mdr_watchdog` (a counter with clear, enable, and a terminal compare to TIMEOUT) instantiated once; the rest is flat.

Test Plan:
- Word read, zero-wait memory: read_from_mm pulse, mem_ack next cycle with mem_rdata=16'hBEEF → r=16'hBEEF two cycles after the pulse; busy high for exactly 1 cycle.
- Write with bypass: mdr_in=1, write_to_mm=1, bus_in=16'h1234, r previously 16'h0000 → reg_out=16'h1234 in the same cycle; mem_wdata=16'h1234, mem_we=1, mem_be=2'b11; r=16'h1234 after the edge.
- Byte read, sign_ext=1, mem_rdata=16'h0080 → r=16'hFF80; with sign_ext=0 → r=16'h0080; mem_be=2'b01 in both cases.
- Timeout: TIMEOUT=15, read with no ack → mem_req drops after 15 wait cycles, bus_err=1, r unchanged; err_clr pulse → bus_err=0.
- Stall: mem_ack delayed 5 cycles, mdr_in pulsed with bus_in=16'hAAAA during the wait → r ends equal to mem_rdata, not 16'hAAAA; mem_wdata stable throughout.
- Async reset asserted mid-RD_WAIT → mem_req=0, busy=0, r=0 immediately, without waiting for a clock edge; a mem_ack arriving afterwards has no effect.
